pitch_sdram_bridge: RTL
=======================

Name: pitch_sdram_bridge

Overview:
Responder side of the pitch-core SDRAM request interface. Accepts single-word read/write requests from the pitch core (level read/write, address, write data) and executes each as one pipelined Avalon-MM transfer to the SDRAM controller. Returns read data and a one-cycle finished pulse per request. Sits between the pitch core and the SDRAM controller master port.

Parameters:
ADDR_W, 23, word address width on both sides
DATA_W, 32, data width; bits [31:16] = left sample, [15:0] = right sample
TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
pitch_read  in  1  read request, level
pitch_write  in  1  write request, level
pitch_addr  in  ADDR_W  request word address
pitch_writedata  in  DATA_W  write data
pitch_readdata  out  DATA_W  read data; valid while pitch_sdram_finished=1 and held until the next read completes
pitch_sdram_finished  out  1  one-cycle completion pulse
avm_address  out  ADDR_W  Avalon address
avm_read  out  1  Avalon read command
avm_write  out  1  Avalon write command
avm_writedata  out  DATA_W  Avalon write data
avm_byteenable  out  DATA_W/8  all ones whenever a command is active, else 0
avm_readdata  in  DATA_W  Avalon read data
avm_readdatavalid  in  1  Avalon read data strobe
avm_waitrequest  in  1  Avalon stall
bridge_busy  out  1  high in every state except IDLE
bridge_error  out  1  sticky timeout flag (optional feature)

Behaviour:
- Reset (i_rst_n=0, async): state=IDLE. All outputs 0, including pitch_readdata and bridge_error. Any in-flight Avalon transfer is abandoned.
- All outputs are registered.
- States: IDLE, RD_CMD, RD_WAIT, WR_CMD, DONE, GAP.
- IDLE: samples the request inputs.
  - pitch_read=1: latch pitch_addr, assert avm_read next cycle, go to RD_CMD.
  - else pitch_write=1: latch addr and data, assert avm_write next cycle, go to WR_CMD.
  - Read and write both high: read wins; write ignored.
- RD_CMD: hold avm_read, avm_address and byteenable while avm_waitrequest=1.
  - On the cycle with waitrequest=0: drop avm_read next cycle, go to RD_WAIT.
  - If avm_readdatavalid=1 in that same cycle: capture data and go straight to DONE.
- RD_WAIT: on avm_readdatavalid=1, capture avm_readdata into pitch_readdata and go to DONE.
- WR_CMD: hold avm_write, avm_address, avm_writedata while waitrequest=1. Accepted (waitrequest=0) -> DONE.
- DONE: pitch_sdram_finished=1 for exactly this one cycle -> GAP.
- GAP: one cycle in which requests are ignored, so the client can update or drop its registered request -> IDLE.
- Latency with zero waitrequest:
  - Request sampled in IDLE at cycle 0; command on the Avalon bus at cycle 1.
  - Write: finished at cycle 2.
  - Read: finished one cycle after readdatavalid (minimum cycle 2).
- Back-to-back requests: the earliest next sample is 2 cycles after the finished pulse.
- avm_readdatavalid in IDLE, WR_CMD, DONE or GAP (stale/post-reset) is ignored; pitch_readdata is unchanged.
- Changes to the request inputs after sampling have no effect until the next IDLE.
- Only one outstanding transfer at any time; no pipelining of reads.

Optional Feature:
PITCH_BRIDGE_TIMEOUT_EN
- Defined:
  - A counter clears on entry to RD_CMD/WR_CMD and increments every cycle in RD_CMD, RD_WAIT and WR_CMD.
  - When it reaches TIMEOUT_CYCLES-1: drop avm_read/avm_write, set pitch_readdata=0, set bridge_error=1, go to DONE (finished still pulses).
  - bridge_error clears when IDLE next accepts a request.
- Undefined: no counter; the bridge waits indefinitely; bridge_error is constant 0.

Test Plan:
- Read, waitrequest=0, readdatavalid 3 cycles after accept with 32'hA5A5_1234, addr 23'h000010 -> avm_read high exactly 1 cycle at addr 0x10; finished 1 cycle after valid; pitch_readdata=32'hA5A5_1234.
- Write addr 23'h7FFFFF, data 32'hDEAD_BEEF, waitrequest held high 5 cycles -> avm_write, address and data stable for 6 cycles; byteenable=4'hF; finished at the cycle after acceptance.
- pitch_read and pitch_write both high -> only avm_read issued; avm_write never asserts.
- Zero-latency read (readdatavalid in the accept cycle) -> finished next cycle; stray readdatavalid in IDLE -> no finished, readdata unchanged.
- i_rst_n low during RD_WAIT, then late readdatavalid -> all outputs 0 immediately; late data ignored; the next request completes normally.
- With PITCH_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=16, readdatavalid never arrives -> finished pulses after 16 cycles; readdata=0; bridge_error=1, cleared by the next request.

Source files
------------

// File: rtl/pitch_sdram_bridge.sv
// Pitch-core request responder: each level read/write becomes one Avalon-MM transfer.
// Optional watchdog enabled by defining PITCH_BRIDGE_TIMEOUT_EN.
module pitch_sdram_bridge #(
  parameter int unsigned ADDR_W         = 23,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                pitch_read,
  input  logic                pitch_write,
  input  logic [ADDR_W-1:0]   pitch_addr,
  input  logic [DATA_W-1:0]   pitch_writedata,
  output logic [DATA_W-1:0]   pitch_readdata,
  output logic                pitch_sdram_finished,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  input  logic                avm_waitrequest,
  output logic                bridge_busy,
  output logic                bridge_error
);

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD, DONE, GAP} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rd_q, rd_d, wr_q, wr_d;
  logic                fin_q, fin_d, busy_q, busy_d, err_q, err_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic                timeout;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

`ifdef PITCH_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts only while a transfer is outstanding; zero on entry to RD_CMD/WR_CMD.
  always_comb begin
    cnt_d = '0;
    if (state_q == RD_CMD || state_q == RD_WAIT || state_q == WR_CMD) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    fin_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pitch_read) begin
          addr_d  = pitch_addr;
          rd_d    = 1'b1;
          err_d   = 1'b0;
          state_d = RD_CMD;
        end else if (pitch_write) begin
          addr_d  = pitch_addr;
          wdata_d = pitch_writedata;
          wr_d    = 1'b1;
          err_d   = 1'b0;
          state_d = WR_CMD;
        end
      end
      RD_CMD: begin
        if (!avm_waitrequest) begin
          if (avm_readdatavalid) begin
            rdata_d = avm_readdata;
            fin_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RD_WAIT;
          end
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          fin_d   = 1'b1;
          state_d = DONE;
        end else begin
          rd_d = 1'b1;
        end
      end
      RD_WAIT: begin
        if (avm_readdatavalid) begin
          rdata_d = avm_readdata;
          fin_d   = 1'b1;
          state_d = DONE;
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          fin_d   = 1'b1;
          state_d = DONE;
        end
      end
      WR_CMD: begin
        if (!avm_waitrequest) begin
          fin_d   = 1'b1;
          state_d = DONE;
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          fin_d   = 1'b1;
          state_d = DONE;
        end else begin
          wr_d = 1'b1;
        end
      end
      DONE:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    be_d   = (rd_d || wr_d) ? '1 : '0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      be_q    <= be_d;
    end
  end

  assign pitch_readdata       = rdata_q;
  assign pitch_sdram_finished = fin_q;
  assign avm_address          = addr_q;
  assign avm_read             = rd_q;
  assign avm_write            = wr_q;
  assign avm_writedata        = wdata_q;
  assign avm_byteenable       = be_q;
  assign bridge_busy          = busy_q;
  assign bridge_error         = err_q;

endmodule
